math_op_engine: RTL
===================

// Module: math_op_engine
// PURPOSE
//  Multi-cycle arithmetic engine downstream of the math AXI4-Lite register bank.
//  The register bank issues one command (opcode + two operands) over a valid/ready port.
//  The engine computes ADD/SUB in one cycle and MUL/DIV iteratively.
//  It returns a double-width result over a valid/ready response port, which the bank latches into read-back registers.
// PARAMETERS
//  DATA_WIDTH  32  operand width W; results are 2*W (lo/hi words)
// PORTS
//  ACLK        in   1  single clock, all logic rising-edge
//  ARESET      in   1  asynchronous, active-high reset
//  cmd_valid   in   1  command present
//  cmd_ready   out  1  engine idle, command accepted when valid&ready
//  cmd_op      in   2  0=ADD 1=SUB 2=MUL 3=DIV (math_pkg::op_e)
//  cmd_a       in   W  operand A (unsigned)
//  cmd_b       in   W  operand B (unsigned)
//  rsp_valid   out  1  result available
//  rsp_ready   in   1  consumer takes result when valid&ready
//  rsp_lo      out  W  result low word
//  rsp_hi      out  W  result high word
//  rsp_err     out  1  divide-by-zero or unsupported opcode
//  busy        out  1  high in CALC or RESP
// BEHAVIOUR
//  Reset values: rsp_valid=0, rsp_lo=0, rsp_hi=0, rsp_err=0, busy=0.
//  cmd_ready=0 while ARESET is high; cmd_ready=1 in IDLE afterwards.
//  FSM states: IDLE, CALC, RESP. cmd_ready = (state==IDLE) & ~ARESET.
//  IDLE: on accept, operands and opcode are registered.
//   - ADD/SUB and DIV-by-zero go to RESP; rsp_valid rises 1 cycle after accept.
//   - MUL/DIV go to CALC; step counter is loaded with W.
//  CALC: one shift-add (MUL) or restoring-subtract (DIV) step per cycle.
//   - Counter reaches 0 -> RESP; rsp_valid rises W+1 cycles after accept.
//  RESP: rsp_* outputs are held stable until rsp_valid&rsp_ready, then IDLE.
//   - No command is accepted in the handshake cycle; earliest next accept is 1 cycle later.
//  ADD: lo=(a+b)[W-1:0], hi={0..,carry}.
//  SUB: lo=(a-b)[W-1:0], hi={0..,borrow}.
//  MUL: {hi,lo} = a*b, unsigned, full 2W product.
//  DIV: lo=a/b, hi=a%b, unsigned.
//   - b==0: err=1, lo=all-ones, hi=a.
//  rsp_err=0 for all other completed operations.
//  ARESET mid-operation (any state): the operation is dropped, all state and outputs return to reset values.
//   - No stale rsp_valid appears after release.
//  cmd_valid while not ready: ignored; the upstream must hold the command.
//  Counter width clog2(W+1); no wrap, because CALC exits at 0.
// CONFIGURATION
//  MATH_OP_DIV_EN defined: DIV is implemented as above, including the restoring-divide datapath.
//  MATH_OP_DIV_EN undefined: no divider logic is instantiated.
//   - op 3 completes like ADD (1-cycle latency) with err=1, lo=0, hi=0.
// STRUCTURE
//  math_pkg holds: op_e (ADD/SUB/MUL/DIV), state_e (IDLE/CALC/RESP), and the OP_W=2 localparam.
//  Sub-module math_iter_unit implements the iterative MUL/DIV datapath.
//   - It holds the shared accumulator/shift registers and exposes load/step/result.
//   - math_op_engine holds the FSM, handshakes and ADD/SUB.
// TESTING (DATA_WIDTH=32)
//  1. ADD a=0xFFFFFFFF b=0x2 -> lo=0x00000001 hi=0x1 err=0, rsp_valid exactly 1 cycle after accept.
//  2. SUB a=3 b=5 -> lo=0xFFFFFFFE hi=0x1 err=0.
//  3. MUL a=0x00010000 b=0x00010003 -> lo=0x00030000 hi=0x00000001, rsp_valid 33 cycles after accept.
//  4. DIV 100/7 -> lo=14 hi=2.
//   - DIV 100/0 -> err=1 lo=0xFFFFFFFF hi=100, 1-cycle latency.
//   - Built without MATH_OP_DIV_EN: op 3 -> err=1 lo=0 hi=0.
//  5. Hold rsp_ready=0 for 5 cycles after a MUL -> rsp_* stable, cmd_ready=0, busy=1 throughout.
//   - The completion cycle is followed by IDLE.
//  6. Pulse ARESET at CALC step 10 of a MUL -> no rsp_valid, cmd_ready=1 after release.
//   - A following ADD 1+1 -> lo=2 hi=0.

Source files
------------

// File: rtl/math_pkg.sv
// Shared types for the math engine: opcode encoding, FSM state encoding and opcode width.
package math_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2,
        DIV = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/math_iter_unit.sv
// Iterative MUL/DIV datapath. The hi/lo/operand registers are shared by both
// operations: MUL keeps the partial product in {hi,lo}, and DIV keeps the
// remainder in hi and the quotient in lo.
// nxt_hi/nxt_lo are the register values after the current step, so the
// controller can capture the final result on the same edge as the last step.
// The divide step only exists when MATH_OP_DIV_EN is defined.
module math_iter_unit
    import math_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
`ifdef MATH_OP_DIV_EN
    input  logic         is_div,
`endif
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] nxt_lo,
    output logic [W-1:0] nxt_hi
);

    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] opb;
    logic [W:0]   mul_sum;

`ifdef MATH_OP_DIV_EN
    logic [W:0]   div_shift;
    logic [W+1:0] div_trial;
    logic         div_unused;

    // Shift the next dividend bit into the remainder, then trial-subtract the divisor.
    // The result is known to fit in W bits, so the top bits are dropped.
    assign div_shift  = {hi, lo[W-1]};
    assign div_trial  = {1'b0, div_shift} - {2'b00, opb};
    assign div_unused = ^{div_shift[W], div_trial[W]};
`endif

    // Compute the value of one shift-add step, or one restoring-divide step.
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opb} : {(W+1){1'b0}});
        nxt_hi  = mul_sum[W:1];
        nxt_lo  = {mul_sum[0], lo[W-1:1]};
`ifdef MATH_OP_DIV_EN
        if (is_div) begin
            if (div_trial[W+1]) begin
                nxt_hi = div_shift[W-1:0];
                nxt_lo = {lo[W-2:0], 1'b0};
            end else begin
                nxt_hi = div_trial[W-1:0];
                nxt_lo = {lo[W-2:0], 1'b1};
            end
        end
`endif
    end

    // Load the operands when a command is accepted, and advance one step per CALC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi  <= '0;
            lo  <= '0;
            opb <= '0;
        end else if (load) begin
            hi  <= '0;
            lo  <= a;
            opb <= b;
        end else if (step) begin
            hi <= nxt_hi;
            lo <= nxt_lo;
        end
    end

endmodule

// File: rtl/math_op_engine.sv
// Command/response arithmetic engine. ADD and SUB finish in one cycle.
// MUL and DIV take DATA_WIDTH steps in math_iter_unit.
// Define MATH_OP_DIV_EN to build the divider. Without it, op 3 returns err=1 with a zero result.
//
//  state | meaning
//  IDLE  | waiting for a command; cmd_ready high
//  CALC  | iterating MUL/DIV, one step per cycle
//  RESP  | result held on rsp_* until rsp_valid & rsp_ready
module math_op_engine
    import math_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [OP_W-1:0]       cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_lo,
    output logic [DATA_WIDTH-1:0] rsp_hi,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(W + 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_RESP = RESP;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [W:0]       add_sum;
    logic [W:0]       sub_dif;
    logic [W-1:0]     iter_lo;
    logic [W-1:0]     iter_hi;
    logic             accept;
`ifdef MATH_OP_DIV_EN
    logic             op_div;
`endif

    assign cmd_ready = (state == ST_IDLE) && !ARESET;
    assign busy      = (state != ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign add_sum   = {1'b0, cmd_a} + {1'b0, cmd_b};
    assign sub_dif   = {1'b0, cmd_a} - {1'b0, cmd_b};

    math_iter_unit #(.W(W)) u_iter (
        .clk    (ACLK),
        .rst    (ARESET),
        .load   (accept),
        .step   (state == ST_CALC),
`ifdef MATH_OP_DIV_EN
        .is_div (op_div),
`endif
        .a      (cmd_a),
        .b      (cmd_b),
        .nxt_lo (iter_lo),
        .nxt_hi (iter_hi)
    );

    // Control FSM and response registers. The counter is loaded with W and CALC exits when it reaches 0.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_lo    <= '0;
            rsp_hi    <= '0;
            rsp_err   <= 1'b0;
`ifdef MATH_OP_DIV_EN
            op_div    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (op_e'(cmd_op))
                            ADD: begin
                                rsp_lo    <= add_sum[W-1:0];
                                rsp_hi    <= {{(W-1){1'b0}}, add_sum[W]};
                                rsp_err   <= 1'b0;
                                rsp_valid <= 1'b1;
                                state     <= ST_RESP;
                            end
                            SUB: begin
                                rsp_lo    <= sub_dif[W-1:0];
                                rsp_hi    <= {{(W-1){1'b0}}, sub_dif[W]};
                                rsp_err   <= 1'b0;
                                rsp_valid <= 1'b1;
                                state     <= ST_RESP;
                            end
                            MUL: begin
                                cnt    <= CNT_W'(W);
`ifdef MATH_OP_DIV_EN
                                op_div <= 1'b0;
`endif
                                state  <= ST_CALC;
                            end
                            DIV: begin
`ifdef MATH_OP_DIV_EN
                                if (cmd_b == '0) begin
                                    rsp_lo    <= {W{1'b1}};
                                    rsp_hi    <= cmd_a;
                                    rsp_err   <= 1'b1;
                                    rsp_valid <= 1'b1;
                                    state     <= ST_RESP;
                                end else begin
                                    cnt    <= CNT_W'(W);
                                    op_div <= 1'b1;
                                    state  <= ST_CALC;
                                end
`else
                                rsp_lo    <= '0;
                                rsp_hi    <= '0;
                                rsp_err   <= 1'b1;
                                rsp_valid <= 1'b1;
                                state     <= ST_RESP;
`endif
                            end
                        endcase
                    end
                end
                ST_CALC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        rsp_lo    <= iter_lo;
                        rsp_hi    <= iter_hi;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
